// File: rtl/neuromorphic_asic_bridge_top.sv
// AXI4-Lite register bridge to a four-neuron integrate-and-fire network.
// The network advances once per TICK_DIV clock cycles; spike counts are readable over AXI.
module neuromorphic_asic_bridge_top #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        pwm_clk,
    input  logic [8:0]  S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [8:0]  S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic        VP,
    input  logic        VN,
    output logic [3:0]  XADC_MUXADDR,
    output logic [7:0]  leds,
    output logic [15:0] digit
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_NET_OUT = 3'd1,
        REG_WEIGHTS = 3'd2,
        REG_DEBUG   = 3'd3,
        REG_CNT0    = 3'd4,
        REG_CNT1    = 3'd5,
        REG_CNT2    = 3'd6,
        REG_CNT3    = 3'd7
    } reg_idx_e;

    logic [31:0]       ctrl_q, ctrl_d, weights_q, weights_d, debug_q, debug_d;
    logic [3:0][31:0]  cnt_q, cnt_d;
    logic [3:0][7:0]   pot_q, pot_d;
    logic [3:0]        flags_q, flags_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [3:0]        mux_q, mux_d;
    logic              awready_q, awready_d, bvalid_q, bvalid_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [3:0][8:0]   sum;
    logic [31:0]       rd_data;
    reg_idx_e          wr_idx, rd_idx;
    logic              wr_commit, clr, tick, tick_eff;
    logic              unused_inputs;

    assign unused_inputs = ^{pwm_clk, VP, VN, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx    = reg_idx_e'(S_AXI_AWADDR[4:2]);
    assign rd_idx    = reg_idx_e'(S_AXI_ARADDR[4:2]);
    assign wr_commit = awready_q && (S_AXI_AWADDR[8:5] == 4'd0);
    assign clr       = wr_commit && (wr_idx == REG_DEBUG) && S_AXI_WDATA[2];
    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    // A clear landing on the tick edge swallows that tick entirely.
    assign tick_eff  = tick && !clr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = {1'b0, pot_q[i]} + {1'b0, weights_q[8*i +: 8]};
        end
    end

    always_comb begin
        rd_data = '0;
        if (S_AXI_ARADDR[8:5] == 4'd0) begin
            case (rd_idx)
                REG_CTRL:    rd_data = ctrl_q;
                REG_NET_OUT: rd_data = {tick_cnt_q, 8'h00, mux_q, flags_q};
                REG_WEIGHTS: rd_data = weights_q;
                REG_DEBUG:   rd_data = debug_q;
                REG_CNT0:    rd_data = cnt_q[0];
                REG_CNT1:    rd_data = cnt_q[1];
                REG_CNT2:    rd_data = cnt_q[2];
                REG_CNT3:    rd_data = cnt_q[3];
                default:     rd_data = '0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch below can infer a latch.
        ctrl_d     = ctrl_q;
        weights_d  = weights_q;
        debug_d    = debug_q;
        cnt_d      = cnt_q;
        pot_d      = pot_q;
        flags_d    = flags_q;
        tick_cnt_d = tick_cnt_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;

        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        bvalid_d  = awready_q || (bvalid_q && !S_AXI_BREADY);
        arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
        rvalid_d  = arready_q || (rvalid_q && !S_AXI_RREADY);
        rdata_d   = arready_q ? rd_data : rdata_q;

        if (wr_commit) begin
            case (wr_idx)
                REG_CTRL:    ctrl_d    = S_AXI_WDATA;
                REG_WEIGHTS: weights_d = S_AXI_WDATA;
                REG_DEBUG:   debug_d   = S_AXI_WDATA & ~32'h0000_0004;
                default:     ;
            endcase
        end

        mux_d = ctrl_q[1] ? (tick_eff ? mux_q + 4'd1 : mux_q) : ctrl_q[7:4];

        if (clr) begin
            cnt_d      = '0;
            pot_d      = '0;
            flags_d    = '0;
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
            for (int i = 0; i < 4; i++) begin
                flags_d[i] = 1'b0;
                if (ctrl_q[0]) begin
                    if (sum[i] >= {1'b0, ctrl_q[15:8]}) begin
                        flags_d[i] = 1'b1;
                        pot_d[i]   = 8'd0;
                        cnt_d[i]   = cnt_q[i] + 32'd1;
                    end else begin
                        pot_d[i]   = sum[i][7:0];
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q     <= '0;
            weights_q  <= '0;
            debug_q    <= '0;
            cnt_q      <= '0;
            pot_q      <= '0;
            flags_q    <= '0;
            tick_cnt_q <= '0;
            presc_q    <= '0;
            mux_q      <= '0;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            weights_q  <= weights_d;
            debug_q    <= debug_d;
            cnt_q      <= cnt_d;
            pot_q      <= pot_d;
            flags_q    <= flags_d;
            tick_cnt_q <= tick_cnt_d;
            presc_q    <= presc_d;
            mux_q      <= mux_d;
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign XADC_MUXADDR  = mux_q;
    assign leds          = debug_q[7:0];
    assign digit         = {cnt_q[3][3:0], cnt_q[2][3:0], cnt_q[1][3:0], cnt_q[0][3:0]};

endmodule

// File: tb/tb_neuromorphic_asic_bridge_top.sv
// Directed bench for neuromorphic_asic_bridge_top: AXI register access, network ticks,
// clear priority, mux sequencing and AXI backpressure.
module tb_neuromorphic_asic_bridge_top;

    localparam int unsigned TICK_DIV = 200;
    localparam int unsigned HS_LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_clk = 1'b0;
    logic [8:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  xadc;
    logic [7:0]  leds;
    logic [15:0] digit;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned tb_presc;
    logic [31:0] rd;
    logic [31:0] exp16 [8];

    neuromorphic_asic_bridge_top #(.TICK_DIV(TICK_DIV)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .pwm_clk       (pwm_clk),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .VP            (1'b0),
        .VN            (1'b0),
        .XADC_MUXADDR  (xadc),
        .leds          (leds),
        .digit         (digit)
    );

    always #10 clk = ~clk;
    always #7  pwm_clk = ~pwm_clk;

    // Independent prescaler model: a tick lands on the edge where tb_presc == TICK_DIV-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_presc <= 0;
        else        tb_presc <= (tb_presc == TICK_DIV - 1) ? 0 : tb_presc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks are entered and left on a falling edge.
    task automatic axi_write(input logic [8:0] a, input logic [31:0] d);
        int n;
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < HS_LIMIT);
        check($sformatf("awready@%03h", a), {31'd0, awready & wready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < HS_LIMIT) begin @(negedge clk); n++; end
        check($sformatf("bvalid@%03h", a), {29'd0, bresp, bvalid}, 32'd1);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [8:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < HS_LIMIT);
        check($sformatf("arready@%03h", a), {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < HS_LIMIT) begin @(negedge clk); n++; end
        check($sformatf("rvalid@%03h", a), {29'd0, rresp, rvalid}, 32'd1);
        d = rdata;
        @(negedge clk);
    endtask

    task automatic read_check(input logic [8:0] a, input logic [31:0] mask, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check($sformatf("rd@%03h", a), v & mask, exp);
    endtask

    task automatic align(input int unsigned p);
        while (tb_presc != p) @(negedge clk);
    endtask

    task automatic wait_ticks(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            while (tb_presc != TICK_DIV - 1) @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        exp16 = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEB, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        check("rst_xadc",  {28'd0, xadc}, 32'd0);
        check("rst_leds",  {24'd0, leds}, 32'd0);
        check("rst_digit", {16'd0, digit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check(9'h000, 32'hFFFF_FFFF, 32'h0);
        read_check(9'h010, 32'hFFFF_FFFF, 32'h0);

        // Fill every address with 0xDEADBEEF inside one tick-free window
        wait_ticks(1);
        for (int i = 0; i < 8; i++) axi_write(9'(i * 4), 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) read_check(9'(i * 4), 32'hFFFF_FFFF, exp16[i]);
        check("leds_eb", {24'd0, leds}, 32'h0000_00EB);
        axi_write(9'h108, 32'h1111_1111);
        axi_write(9'h100, 32'h2222_2222);
        read_check(9'h008, 32'hFFFF_FFFF, 32'hDEADBEEF);
        read_check(9'h000, 32'hFFFF_FFFF, 32'hDEADBEEF);
        read_check(9'h100, 32'hFFFF_FFFF, 32'h0);
        read_check(9'h10C, 32'hFFFF_FFFF, 32'h0);
        axi_write(9'h000, 32'h0);

        // Ten enabled ticks with unit weights and THRESH=0
        align(TICK_DIV / 2);
        axi_write(9'h008, 32'h0101_0101);
        axi_write(9'h000, 32'h0000_0001);
        wait_ticks(10);
        align(TICK_DIV / 2);
        axi_write(9'h000, 32'h0);
        for (int i = 0; i < 4; i++) read_check(9'(16 + 4 * i), 32'hFFFF_FFFF, 32'd10);
        check("digit_aaaa", {16'd0, digit}, 32'h0000_AAAA);
        read_check(9'h004, 32'h0000_FFFF, 32'h0000_000F);

        // Clear command
        align(TICK_DIV / 2);
        axi_write(9'h00C, 32'h0000_0004);
        read_check(9'h00C, 32'hFFFF_FFFF, 32'h0);
        check("clr_leds",  {24'd0, leds}, 32'h0);
        check("clr_digit", {16'd0, digit}, 32'h0);
        for (int i = 0; i < 4; i++) read_check(9'(16 + 4 * i), 32'hFFFF_FFFF, 32'd0);
        read_check(9'h004, 32'hFFFF_FFFF, 32'h0);
        wait_ticks(3);
        align(TICK_DIV / 2);
        read_check(9'h004, 32'hFFFF_FFFF, 32'h0003_0000);

        // THRESH=12 with W0=4: neuron 0 fires every third tick
        align(TICK_DIV / 2);
        axi_write(9'h008, 32'h0000_0004);
        axi_write(9'h000, 32'h0000_0C01);
        wait_ticks(6);
        align(TICK_DIV / 2);
        read_check(9'h004, 32'h0000_FFFF, 32'h0000_0001);
        read_check(9'h010, 32'hFFFF_FFFF, 32'd2);
        wait_ticks(1);
        align(TICK_DIV / 2);
        axi_write(9'h000, 32'h0);
        read_check(9'h010, 32'hFFFF_FFFF, 32'd2);
        for (int i = 1; i < 4; i++) read_check(9'(16 + 4 * i), 32'hFFFF_FFFF, 32'd0);
        read_check(9'h004, 32'h0000_000F, 32'h0);

        // Clear committed on the tick edge wins over the tick
        align(TICK_DIV / 2);
        axi_write(9'h008, 32'h0101_0101);
        axi_write(9'h000, 32'h0000_0001);
        wait_ticks(1);
        align(TICK_DIV - 2);
        axi_write(9'h00C, 32'h0000_0004);
        read_check(9'h010, 32'hFFFF_FFFF, 32'd0);
        read_check(9'h01C, 32'hFFFF_FFFF, 32'd0);
        read_check(9'h004, 32'hFFFF_FFFF, 32'h0);
        axi_write(9'h000, 32'h0);

        // Auto mux sequencing and manual MUXSEL
        align(TICK_DIV / 2);
        axi_write(9'h000, 32'h0000_0002);
        check("mux_start", {28'd0, xadc}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            wait_ticks(1);
            check($sformatf("mux_k%0d", k), {28'd0, xadc}, 32'(k % 16));
        end
        align(TICK_DIV / 2);
        axi_write(9'h000, 32'h0000_0050);
        check("mux_sel5", {28'd0, xadc}, 32'd5);
        read_check(9'h004, 32'h0000_00F0, 32'h0000_0050);

        // Write backpressure, WSTRB=0, second offer refused
        align(TICK_DIV / 2);
        awaddr = 9'h008; wdata = 32'h1234_5678; wstrb = 4'h0;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!awready && n < HS_LIMIT);
        end
        check("bp_aw_hs", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awaddr = 9'h000; wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("bp_no_aw", {31'd0, awready}, 32'd0);
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; wstrb = 4'hF;
        @(negedge clk);
        check("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);

        // Read backpressure
        araddr = 9'h008; arvalid = 1'b1; rready = 1'b0;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!arready && n < HS_LIMIT);
        end
        check("bp_ar_hs", {31'd0, arready}, 32'd1);
        @(negedge clk);
        araddr = 9'h000;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid_hold", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_hold", rdata, 32'h1234_5678);
            check("bp_no_ar", {31'd0, arready}, 32'd0);
            @(negedge clk);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("bp_rvalid_drop", {31'd0, rvalid}, 32'd0);
        read_check(9'h000, 32'hFFFF_FFFF, 32'h0000_0050);
        read_check(9'h008, 32'hFFFF_FFFF, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/neuromorphic_asic_bridge_top.md
NEUROMORPHIC_ASIC_BRIDGE_TOP -- requirements
Module: neuromorphic_asic_bridge_top

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: network tick period in S_AXI_ACLK cycles (min 2).
REQ-002 SHALL have ports:
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- pwm_clk  in  1  pin-compatibility input; unused; SHALL NOT clock or affect any logic.
- S_AXI_AWADDR  in  9  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  ignored; every write is full-word.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  always 00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  9  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- VP, VN  in  1  analog pins; unused.
- XADC_MUXADDR  out  4  external mux select.
- leds  out  8  DEBUG[7:0].
- digit  out  16  {CNT3[3:0],CNT2[3:0],CNT1[3:0],CNT0[3:0]}.

Function
REQ-003 Write handshake: when AWVALID&WVALID and BVALID=0, assert AWREADY and WREADY together for exactly one cycle and commit the write on that edge; assert BVALID the next cycle; hold BVALID until BREADY=1.
REQ-004 Read handshake: when ARVALID and RVALID=0 and ARREADY=0, assert ARREADY for one cycle; next cycle assert RVALID with RDATA registered; hold RVALID and RDATA until RREADY=1; accept no new read while RVALID=1.
REQ-005 Decode on addr[4:2]; addr[1:0] ignored; addresses >= 0x20 read 0 and writes are discarded, with a normal OKAY response.
REQ-006 Register map:
- 0x00 CTRL RW: bit0 EN; bit1 AUTO; [7:4] MUXSEL; [15:8] THRESH; all 32 bits stored.
- 0x04 NET_OUT RO: [3:0] spike flags of last tick; [7:4] XADC_MUXADDR; [31:16] tick counter, wrapping.
- 0x08 WEIGHTS RW: byte i is weight W_i of neuron i.
- 0x0C DEBUG RW: bit2 is a clear command and always reads 0; other bits are stored.
- 0x10/0x14/0x18/0x1C CNT0..CNT3 RO: 32-bit spike counters, wrapping.
REQ-007 Writes to RO registers SHALL be ignored.
REQ-008 Writing DEBUG with bit2=1 SHALL zero CNT0..3, the potentials, the NET_OUT flags and the tick counter on the commit edge; the other DEBUG bits are stored normally in the same write.
REQ-009 Prescaler counts 0..TICK_DIV-1 continuously; a tick is one cycle when it wraps; the tick counter increments on every tick.
REQ-010 On a tick with EN=1, for each neuron i: s = P_i + W_i (9-bit); if s >= THRESH then flag_i=1, P_i=0, CNT_i+1; else flag_i=0, P_i=s[7:0].
REQ-011 On a tick with EN=0: potentials and counters hold; flags are cleared.
REQ-012 THRESH=0 SHALL make every enabled neuron spike on every tick.
REQ-013 XADC_MUXADDR: if AUTO=1, increments by 1 on every tick and wraps 15->0; if AUTO=0, equals MUXSEL.
REQ-014 A clear command coinciding with a tick SHALL take priority; the tick is lost.

Reset
REQ-015 Asynchronous assertion SHALL zero all registers, potentials, counters, prescaler and the tick counter, and deassert all AXI valid/ready outputs; XADC_MUXADDR=0, leds=0, digit=0; synchronous release.

Verification
REQ-016 Write 0xDEADBEEF to 0x00..0x1C, then read all -> CTRL=0xDEADBEEF, WEIGHTS=0xDEADBEEF, DEBUG=0xDEADBEEB, leds=0xEB, RO regs show counts only.
REQ-017 Write DEBUG=0x4 -> DEBUG reads 0, CNT0..3=0, leds=0x00.
REQ-018 CTRL=0x00000001, WEIGHTS=0x01010101, 200000 ns at 20 ns clock (10 ticks) -> each CNT=10, digit=0xAAAA.
REQ-019 CTRL=0x00000C01, WEIGHTS=0x00000004 -> CNT0 increments every 3rd tick; CNT1..3 stay 0.
REQ-020 CTRL=0x00000002 -> XADC_MUXADDR advances once per tick and wraps 15->0; CTRL=0x00000050 -> XADC_MUXADDR=5.
REQ-021 Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable, no second transaction is accepted, and WSTRB=0 still writes.
